// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: numInputs signed Q6.10 products into a Q12.20 sum, plus bias.
// Define NEURON_MAC_SAT_EN for saturating accumulation with a sticky ovf flag; default build wraps.
module neuron_mac #(
  parameter int numInputs       = 4,
  parameter int dataWidth       = 16,
  parameter int weightWidth     = 16,
  parameter int sumWidth        = 32,
  parameter int dataFracWidth   = 10,
  parameter int weightFracWidth = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [dataWidth-1:0]   bias_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [dataWidth-1:0]   data_in,
  input  logic [weightWidth-1:0] weight_in,
  output logic [sumWidth-1:0]    sum_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

  localparam int CntW      = (numInputs > 1) ? $clog2(numInputs) : 1;
  localparam int ProdW     = dataWidth + weightWidth;
  // Bias is Q.dataFrac; the sum carries dataFrac+weightFrac fraction bits.
  localparam int BiasShift = (dataFracWidth + weightFracWidth) - dataFracWidth;

  state_t                state_q, state_d;
  logic [sumWidth-1:0]   acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [dataWidth-1:0]  bias_q, bias_d;
  logic                  ovf_q, ovf_d;

  logic signed [ProdW-1:0] prod_s;
  logic [sumWidth-1:0]     prod_ext_s;
  logic [sumWidth-1:0]     bias_ext_s;
  logic [sumWidth-1:0]     addend_s;
  logic [sumWidth:0]       sum_s;

  // Returns {overflow, result}; overflow can only be set in the saturating build.
  function automatic logic [sumWidth:0] acc_add(input logic [sumWidth-1:0] a,
                                                input logic [sumWidth-1:0] b);
`ifdef NEURON_MAC_SAT_EN
    logic [sumWidth:0] wide;
    wide = {a[sumWidth-1], a} + {b[sumWidth-1], b};
    if (wide[sumWidth] != wide[sumWidth-1]) begin
      acc_add = {1'b1, wide[sumWidth], {(sumWidth-1){~wide[sumWidth]}}};
    end else begin
      acc_add = {1'b0, wide[sumWidth-1:0]};
    end
`else
    acc_add = {1'b0, a + b};
`endif
  endfunction

  assign prod_s     = $signed(data_in) * $signed(weight_in);
  assign prod_ext_s = sumWidth'(prod_s);
  assign bias_ext_s = sumWidth'($signed(bias_q)) << BiasShift;
  assign addend_s   = (state_q == BIAS) ? bias_ext_s : prod_ext_s;
  assign sum_s      = acc_add(acc_q, addend_s);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bias_d  = bias_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          bias_d  = bias_in;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_s[sumWidth-1:0];
          ovf_d = ovf_q | sum_s[sumWidth];
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(numInputs - 1)) begin
            state_d = BIAS;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      BIAS: begin
        acc_d   = sum_s[sumWidth-1:0];
        ovf_d   = ovf_q | sum_s[sumWidth];
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      bias_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bias_q  <= bias_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign sum_out   = out_valid ? acc_q : '0;
  assign ovf       = ovf_q;

endmodule
